// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned WORD_OFS    = 2;

  // Misaligned, or any address bit set above the RAM's byte span.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + WORD_OFS)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the MEM stage and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, addr_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, addr_err, stall
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered synchronous read.
module dmem_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding access, fixed wait states,
// one-cycle response pulse, plus shadow registers for two fixed words.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] OUT1_ADDR = 32'h0,
  parameter logic [31:0] OUT2_ADDR = 32'h4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [31:0]       out1,
  output logic [31:0]       out2
);

  localparam logic [3:0] CNT_INIT = (LATENCY > LATENCY_MAX) ? 4'(LATENCY_MAX - 1)
                                                              : 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_err;
  logic        commit;
  logic        wr_ok;
  logic        from_ram;
  logic [31:0] data_q;
  logic [31:0] ram_rdata;

  assign cap_err = addr_bad(cap_addr, ADDR_W);
  assign commit  = (state == BUSY) && (cnt == '0);
  assign wr_ok   = cap_write && !cap_err;

  assign bus.req_ready  = (state == IDLE);
  assign bus.stall      = ((state == IDLE) && bus.req_valid) || (state == BUSY);
  // Read data lands in the RAM's own output register on the commit edge;
  // writes and errors are answered from data_q instead.
  assign bus.resp_rdata = from_ram ? ram_rdata : data_q;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .we    (wr_ok),
    .addr  (cap_addr[ADDR_W+1:WORD_OFS]),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_write      <= 1'b0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.addr_err   <= 1'b0;
      from_ram       <= 1'b0;
      data_q         <= '0;
      out1           <= '0;
      out2           <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cnt       <= CNT_INIT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.addr_err   <= cap_err;
            from_ram       <= !cap_write && !cap_err;
            data_q         <= wr_ok ? cap_wdata : '0;
            if (wr_ok && (cap_addr == OUT1_ADDR)) out1 <= cap_wdata;
            if (wr_ok && (cap_addr == OUT2_ADDR)) out2 <= cap_wdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the responder.
module tb_dmem_responder;

  localparam int          AW  = 10;
  localparam int          LAT = 2;
  localparam logic [31:0] O1  = 32'h0;
  localparam logic [31:0] O2  = 32'h4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] out1, out2;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W    (AW),
    .LATENCY   (LAT),
    .OUT1_ADDR (O1),
    .OUT2_ADDR (O2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .out1 (out1),
    .out2 (out2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  logic [31:0] mmem  [0:1023];
  bit          known [0:1023];
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_acc = 0;
  logic        m_w;
  logic [31:0] m_a, m_d;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;
  logic [31:0] m_o1 = '0, m_o2 = '0;

  // Per-step observations for directed checks
  bit          saw_acc, saw_resp;
  int          acc_cyc, resp_cyc, resp_cnt = 0;
  logic [31:0] acc_a, acc_d;
  logic [31:0] r_rd, r_o1, r_o2;
  logic        r_err;

  function automatic logic bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd4 << AW));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic cmp_cycle();
    int ph;
    int idx;
    if (!rst) begin
      m_busy = 0; m_rd = '0; m_err = 1'b0; m_o1 = '0; m_o2 = '0;
    end
    ph = m_busy ? (cyc - m_acc) : 0;
    chk("req_ready",  bus.req_ready,  !m_busy);
    chk("stall",      bus.stall,      m_busy ? (ph <= LAT) : bus.req_valid);
    chk("resp_valid", bus.resp_valid, m_busy && (ph == LAT + 1));
    chk("resp_rdata", bus.resp_rdata, m_rd);
    chk("addr_err",   bus.addr_err,   m_err);
    chk("out1",       out1,           m_o1);
    chk("out2",       out2,           m_o2);
    if (bus.resp_valid) begin
      saw_resp = 1; resp_cyc = cyc; resp_cnt++;
      r_rd = bus.resp_rdata; r_err = bus.addr_err; r_o1 = out1; r_o2 = out2;
    end
    if (rst) begin
      if (!m_busy && bus.req_valid) begin
        m_busy = 1; m_acc = cyc;
        m_w = bus.req_write; m_a = bus.req_addr; m_d = bus.req_wdata;
        saw_acc = 1; acc_cyc = cyc; acc_a = m_a; acc_d = m_d;
      end else if (m_busy && ph == LAT) begin
        idx = int'(m_a >> 2);
        if (bad(m_a)) begin
          m_rd = '0; m_err = 1'b1;
        end else if (m_w) begin
          mmem[idx] = m_d; known[idx] = 1; m_rd = m_d; m_err = 1'b0;
          if (m_a == O1) m_o1 = m_d;
          if (m_a == O2) m_o2 = m_d;
        end else begin
          m_rd = mmem[idx]; m_err = 1'b0;
        end
      end else if (m_busy && ph == LAT + 1) begin
        m_busy = 0;
      end
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic r);
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    rst = r; saw_acc = 0; saw_resp = 0;
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int n, ac;
    bit acc, got;
    n = 0; ac = 0; acc = 0; got = 0; lat = -1; rd = '0; er = 1'b0;
    while (!acc && n < 40) begin
      step(1'b1, w, a, d, 1'b1); n++;
      if (saw_acc) begin acc = 1; ac = acc_cyc; end
    end
    while (acc && !got && n < 40) begin
      step(1'b0, 1'b0, '0, '0, 1'b1); n++;
      if (saw_resp) begin got = 1; lat = resp_cyc - ac; rd = r_rd; er = r_err; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL req_timeout addr=%h got=no_response exp=response", a);
    end
  endtask

  int          lat;
  logic [31:0] rd, a, d;
  logic        er, w;
  int          q[$];
  int          rc0;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) known[i] = 0;
    @(posedge clk); #1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_out1",  out1, 32'h0);
    chk("rst_out2",  out2, 32'h0);

    // Write then read back
    do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_echo", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, '0, lat, rd, er);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", er, 1'b0);

    // Shadow registers
    do_req(1'b1, 32'h0, 32'h5, lat, rd, er);
    chk("sh_out1_resp", r_o1, 32'h5);
    do_req(1'b1, 32'h4, 32'h7, lat, rd, er);
    chk("sh_out2_resp", r_o2, 32'h7);
    do_req(1'b0, 32'h0, '0, lat, rd, er);
    chk("sh_rd0", rd, 32'h5);
    chk("sh_keep1", out1, 32'h5);
    chk("sh_keep2", out2, 32'h7);

    // Error accesses
    do_req(1'b1, 32'h11, 32'hCAFEF00D, lat, rd, er);
    chk("mis_err", er, 1'b1);
    chk("mis_rdata", rd, 32'h0);
    do_req(1'b0, 32'h2000, '0, lat, rd, er);
    chk("oor_err", er, 1'b1);
    chk("oor_rdata", rd, 32'h0);
    do_req(1'b0, 32'h10, '0, lat, rd, er);
    chk("post_err_rd", rd, 32'hDEADBEEF);

    // req_valid held high with changing payload
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 32'h100 + 4 * $urandom_range(0, 63), $urandom, 1'b1);
      if (saw_acc) q.push_back(acc_cyc);
    end
    a = acc_a; d = acc_d;
    for (int i = 0; i < 10 && m_busy; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("b2b_count", q.size() >= 5, 1'b1);
    for (int i = 1; i < q.size(); i++) chk("b2b_spacing", q[i] - q[i-1], LAT + 2);
    do_req(1'b0, a, '0, lat, rd, er);
    chk("b2b_last_commit", rd, d);

    // Reset during the commit cycle of a write to 0x0
    step(1'b1, 1'b1, 32'h0, 32'h1234, 1'b1);
    chk("rm_accept", saw_acc, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    rc0 = resp_cnt;
    step(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rm_no_resp", resp_cnt - rc0, 0);
    chk("rm_out1", out1, 32'h0);
    do_req(1'b0, 32'h0, '0, lat, rd, er);
    chk("rm_rd_prior", rd, 32'h5);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int sel, idx;
      sel = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (sel == 0) begin
        a = 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
      end else if (sel == 1) begin
        a = $urandom | 32'h0000_1000;
      end else begin
        idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 63);
        a = 32'(4 * idx);
        if (!w && !known[idx]) w = 1'b1;
      end
      do_req(w, a, d, lat, rd, er);
      chk("rnd_latency", lat, LAT + 1);
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, '0, '0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
